// File: rtl/cla_pkg.sv
// Shared types and constants for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } cla_op_e;

   localparam int GROUP_W = 4;

   typedef struct packed {
      logic cout;
      logic overflow;
      logic zero;
      logic negative;
   } cla_flags_t;

endpackage

// File: rtl/cla_group_4.sv
// 4-bit carry-lookahead group: local sum plus group generate/propagate.
module cla_group_4
   import cla_pkg::*;
(
   input  logic [GROUP_W-1:0] a,
   input  logic [GROUP_W-1:0] b,
   input  logic               cin,
   output logic [GROUP_W-1:0] sum,
   output logic               G,
   output logic               P
);

   logic [GROUP_W-1:0] g_bit;
   logic [GROUP_W-1:0] p_bit;
   logic [GROUP_W-1:0] c;

   always_comb begin
      g_bit = a & b;
      p_bit = a ^ b;
      c[0]  = cin;
      c[1]  = g_bit[0] | (p_bit[0] & cin);
      c[2]  = g_bit[1] | (p_bit[1] & g_bit[0]) | (p_bit[1] & p_bit[0] & cin);
      c[3]  = g_bit[2] | (p_bit[2] & g_bit[1]) | (p_bit[2] & p_bit[1] & g_bit[0])
            | (p_bit[2] & p_bit[1] & p_bit[0] & cin);
      sum   = p_bit ^ c;
      G     = g_bit[3] | (p_bit[3] & g_bit[2]) | (p_bit[3] & p_bit[2] & g_bit[1])
            | (p_bit[3] & p_bit[2] & p_bit[1] & g_bit[0]);
      P     = &p_bit;
   end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead add/sub: one WIDTH/STAGES chunk per stage, registered chunk carry.
// Define CLA_PIPE_FLAGS_EN to build the zero/negative flag logic; otherwise those outputs are 0.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   if ((STAGES < 1) || (WIDTH % (GROUP_W * STAGES) != 0)) begin : g_bad_cfg
      $fatal(1, "cla_pipe_adder: WIDTH must be a multiple of 4*STAGES");
   end

   localparam int CW = WIDTH / STAGES;
   localparam int NG = CW / GROUP_W;
   localparam int LS = STAGES - 1;

   cla_op_e          op_e;
   logic             adv;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   cla_flags_t       flags_q, flags_d;

   assign op_e     = cla_op_e'(op);
   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv && !flush;

   // Stage j holds the word with chunks below j already summed, plus only the b chunks still pending.
   for (genvar j = 0; j < STAGES; j++) begin : g_stg
      localparam int RW = WIDTH - j * CW;

      logic [WIDTH-1:0] x_q, x_d, x_src, x_nx;
      logic [RW-1:0]    y_q, y_d, y_src;
      logic             c_q, c_d, c_src, c_nx;
      logic             v_q, v_d, v_src;
      logic [CW-1:0]    cs;
      logic [NG:0]      gc;
      logic [NG-1:0]    grp_g, grp_p;

      if (j == 0) begin : g_entry
         assign x_src = a;
         assign y_src = (op_e == OP_SUB) ? ~b : b;
         assign c_src = (op_e == OP_SUB) ? 1'b1 : cin;
         assign v_src = in_valid && in_ready;
      end else begin : g_link
         assign x_src = g_stg[j-1].x_nx;
         assign y_src = g_stg[j-1].y_q[RW+CW-1:CW];
         assign c_src = g_stg[j-1].c_nx;
         assign v_src = g_stg[j-1].v_q;
      end

      always_comb begin
         x_d = x_q;
         y_d = y_q;
         c_d = c_q;
         if (adv) begin
            x_d = x_src;
            y_d = y_src;
            c_d = c_src;
         end
         v_d = flush ? 1'b0 : (adv ? v_src : v_q);
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            x_q <= '0;
            y_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
         end else begin
            x_q <= x_d;
            y_q <= y_d;
            c_q <= c_d;
            v_q <= v_d;
         end
      end

      for (genvar g = 0; g < NG; g++) begin : g_grp
         cla_group_4 u_grp (
            .a   (x_q[j*CW + g*GROUP_W +: GROUP_W]),
            .b   (y_q[g*GROUP_W +: GROUP_W]),
            .cin (gc[g]),
            .sum (cs[g*GROUP_W +: GROUP_W]),
            .G   (grp_g[g]),
            .P   (grp_p[g])
         );
      end

      // Second-level lookahead: every group carry is a flat AND-OR of G/P and the chunk carry.
      always_comb begin
         logic p_run;
         logic g_acc;
         p_run = 1'b1;
         g_acc = 1'b0;
         gc    = '0;
         gc[0] = c_q;
         for (int g = 0; g < NG; g++) begin
            p_run = 1'b1;
            g_acc = 1'b0;
            for (int i = g; i >= 0; i--) begin
               g_acc = g_acc | (grp_g[i] & p_run);
               p_run = p_run & grp_p[i];
            end
            gc[g+1] = g_acc | (p_run & c_q);
         end
      end

      always_comb begin
         x_nx = x_q;
         x_nx[j*CW +: CW] = cs;
      end

      assign c_nx = gc[NG];
   end

   logic [WIDTH-1:0] res;
   logic             res_cout;
   logic             msb_cin;

   assign res      = g_stg[LS].x_nx;
   assign res_cout = g_stg[LS].c_nx;
   assign msb_cin  = res[WIDTH-1] ^ g_stg[LS].x_q[WIDTH-1] ^ g_stg[LS].y_q[CW-1];

   always_comb begin
      sum_d   = sum_q;
      flags_d = flags_q;
      if (adv) begin
         sum_d            = res;
         flags_d.cout     = res_cout;
         flags_d.overflow = res_cout ^ msb_cin;
`ifdef CLA_PIPE_FLAGS_EN
         flags_d.zero     = (res == '0);
         flags_d.negative = res[WIDTH-1];
`else
         flags_d.zero     = 1'b0;
         flags_d.negative = 1'b0;
`endif
      end
      out_valid_d = flush ? 1'b0 : (adv ? g_stg[LS].v_q : out_valid_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         flags_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = flags_q.cout;
   assign overflow  = flags_q.overflow;
   assign zero      = flags_q.zero;
   assign negative  = flags_q.negative;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (WIDTH=32, STAGES=2) using directed, hand-computed vectors.
module tb_cla_pipe_adder;

   localparam int WIDTH  = 32;
   localparam int STAGES = 2;

   typedef struct packed {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic        ci;
      logic [31:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   typedef struct packed {
      logic [31:0] s;
      logic        co;
      logic        ov;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   logic             zero;
   logic             negative;

   int   checks   = 0;
   int   failures = 0;
   int   n_out    = 0;
   exp_t sb_q[$];
   vec_t vt [0:11];

   cla_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow),
      .zero      (zero),
      .negative  (negative)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic o, input logic [31:0] xa, input logic [31:0] xb,
                               input logic c, input logic [31:0] s, input logic co, input logic ov);
      vec_t v;
      v.op = o; v.a = xa; v.b = xb; v.ci = c; v.s = s; v.co = co; v.ov = ov;
      return v;
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int idx);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      in_valid = 1'b1;
      op  = vt[idx].op;
      a   = vt[idx].a;
      b   = vt[idx].b;
      cin = vt[idx].ci;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         if (acc) sb_q.push_back('{s: vt[idx].s, co: vt[idx].co, ov: vt[idx].ov});
         #1;
         n++;
      end
      in_valid = 1'b0;
      chk("issue_accept", 32'(acc), 32'd1);
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk(name, 32'(sb_q.size()), 32'd0);
      sync();
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic ez, en;
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_out", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
`ifdef CLA_PIPE_FLAGS_EN
            ez = (e.s == 32'd0);
            en = e.s[31];
`else
            ez = 1'b0;
            en = 1'b0;
`endif
            chk("sum", sum, e.s);
            chk("cout", 32'(cout), 32'(e.co));
            chk("overflow", 32'(overflow), 32'(e.ov));
            chk("zero", 32'(zero), 32'(ez));
            chk("negative", 32'(negative), 32'(en));
            n_out++;
         end
      end
   end

   initial begin
      int   k;
      logic seen;

      vt[0]  = mk(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      vt[1]  = mk(1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0001_0001, 1'b0, 1'b0);
      vt[2]  = mk(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      vt[3]  = mk(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
      vt[4]  = mk(1'b1, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      vt[5]  = mk(1'b1, 32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
      vt[6]  = mk(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
      vt[7]  = mk(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
      vt[8]  = mk(1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      vt[9]  = mk(1'b0, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b0);
      vt[10] = mk(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      vt[11] = mk(1'b0, 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0004, 1'b0, 1'b0);

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = 1'b0;
      a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", sum, 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_negative", 32'(negative), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      sync();

      // single op: latency in cycles after the accepting edge
      issue(0);
      k = 0; seen = 1'b0;
      while (!seen && k < 20) begin
         @(negedge clk);
         seen = out_valid;
         k++;
      end
      chk("latency", 32'(k - 1), 32'(STAGES));
      drain("drain_latency");

      for (int i = 1; i < 7; i++) issue(i);
      drain("drain_b2b");

      // back-to-back ops with a 3-cycle consumer stall after the first result
      fork
         begin
            for (int i = 7; i < 12; i++) issue(i);
         end
         begin
            k = 0; seen = 1'b0;
            while (!seen && k < 20) begin
               @(negedge clk);
               seen = out_valid;
               k++;
            end
            chk("stall_first_out", 32'(seen), 32'd1);
            @(posedge clk);
            #1 out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               chk("stall_in_ready", 32'(in_ready), 32'd0);
               chk("stall_out_valid", 32'(out_valid), 32'd1);
               chk("stall_sum", sum, (sb_q.size() != 0) ? sb_q[0].s : 32'hDEAD_BEEF);
               chk("stall_cout", 32'(cout), (sb_q.size() != 0) ? 32'(sb_q[0].co) : 32'd2);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain("drain_stall");

      // flush with two ops in flight and a third presented
      issue(0);
      issue(1);
      in_valid = 1'b1; op = vt[2].op; a = vt[2].a; b = vt[2].b; cin = vt[2].ci;
      flush = 1'b1;
      sb_q.delete();
      @(negedge clk);
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      sync();
      flush = 1'b0;
      in_valid = 1'b0;
      for (int s = 0; s < STAGES; s++) begin
         @(negedge clk);
         chk("flush_out_valid", 32'(out_valid), 32'd0);
      end
      sync();
      issue(3);
      drain("drain_flush");

      // one-cycle reset with two ops in flight
      issue(4);
      issue(5);
      rst = 1'b1;
      sync();
      rst = 1'b0;
      sb_q.delete();
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_sum", sum, 32'd0);
      chk("mid_rst_cout", 32'(cout), 32'd0);
      chk("mid_rst_overflow", 32'(overflow), 32'd0);
      chk("mid_rst_zero", 32'(zero), 32'd0);
      chk("mid_rst_negative", 32'(negative), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      repeat (6) @(negedge clk);
      sync();
      issue(6);
      drain("drain_rst");

      chk("out_count", 32'(n_out), 32'd14);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups with a second-level lookahead per pipeline stage. The operand width is split into `STAGES` equal chunks. Each chunk is computed in its own cycle, and the chunk carry is registered between stages. Operands are skewed on entry and results de-skewed on exit. It sits in the execute path as the ALU's add/sub/compare engine, with a valid/ready handshake for multi-cycle datapaths.

## Interface
- `WIDTH`, 32, operand/result width; must be a multiple of 4·`STAGES`
- `STAGES`, 2, pipeline stages = latency in cycles; range 1..`WIDTH`/4
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous; drops all in-flight operations
- `in_valid`  in  1  operands present
- `in_ready`  out  1  operands accepted this cycle when `in_valid & in_ready`
- `op`  in  1  `OP_ADD`=0, `OP_SUB`=1
- `a`, `b`  in  `WIDTH`  operands
- `cin`  in  1  carry-in for `OP_ADD`; ignored for `OP_SUB`
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts the result
- `sum`  out  `WIDTH`  result
- `cout`  out  1  carry out of bit `WIDTH`-1; for SUB, 1 = no borrow
- `overflow`  out  1  signed overflow, c[`WIDTH`] ^ c[`WIDTH`-1]
- `zero`, `negative`  out  1  result flags

## Operation
- ADD: `a + b + cin`. SUB: `a + ~b + 1`.
- Chunk width is CW = `WIDTH`/`STAGES`. Stage k adds bits [k·CW +: CW] using the carry registered from stage k-1. Stage 0 uses the effective carry-in.
- Within a chunk:
  - CW/4 `cla_group_4` instances produce group G/P.
  - Group carries come from second-level lookahead. No ripple between groups.
- Skew: chunk k operands are delayed k registers. Chunk k sum is delayed `STAGES`-1-k registers. All chunks emerge aligned.
- Flags are computed in the last stage from the full aligned sum:
  - `zero` = (sum == 0)
  - `negative` = sum[`WIDTH`-1]
  - `overflow` uses the MSB carry-in and carry-out
- Pipeline advance: `adv = !out_valid | out_ready`.
  - All stages shift together on `adv`. This is a global stall.
  - Bubbles are not collapsed.
- `in_ready = adv & !flush`.
- Each stage carries a valid bit. Stage 0 valid is loaded with `in_valid & in_ready` on `adv`.
- Results leave strictly in acceptance order. No op is dropped or duplicated except by `flush`/`rst`.

## Timing
- Latency: an op accepted at edge N drives `out_valid`=1 with its result after edge N+`STAGES`, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one op per cycle while `out_ready`=1.
- Outputs are registered. `sum`/`cout`/`overflow`/`zero`/`negative` are stable while `out_valid & !out_ready`.
- Reset: all valid bits = 0 and all pipeline/output registers = 0.
  - `out_valid`=0, `sum`=0, all flags 0.
  - `in_ready`=1 from the first cycle after reset deassertion.
  - Reset mid-operation discards every in-flight op.
- `flush`: all valid bits cleared at the next edge and `out_valid`=0 the following cycle.
  - `flush` with `in_valid` in the same cycle: the input is not accepted.
  - `flush` with `out_valid & out_ready`: the output transfer completes in that cycle, and `out_valid` is 0 afterwards.
  - `rst` has priority over `flush`.
- Wrap-around: the sum is modulo 2^`WIDTH`. The carry is reported only via `cout`.
- `STAGES`=1: single registered stage, latency 1.

## Configuration
- `CLA_PIPE_FLAGS_EN` defined: the `zero`/`negative` logic and registers are present as specified.
- Undefined: `zero` and `negative` are tied to 0. `cout` and `overflow` are always present.

## Structure
- Package `cla_pkg` contains:
  - `typedef enum logic {OP_ADD, OP_SUB} cla_op_e`
  - `localparam GROUP_W = 4`
  - a packed struct `cla_flags_t {cout, overflow, zero, negative}`
- Sub-module `cla_group_4` (a, b, cin, sum, G, P) is purely combinational and instantiated CW/4 times per stage.
- Elaboration check: fatal error if `WIDTH % (4*STAGES) != 0`.

## Test plan
- `WIDTH`=32, `STAGES`=2, ADD 0xFFFF_FFFF + 0x0000_0001, `cin`=0 -> two cycles later:
  - `sum`=0x0000_0000
  - `cout`=1, `overflow`=0, `zero`=1
- ADD 0x0000_FFFF + 0x0000_0001, `cin`=1 (carry crosses the chunk boundary) -> `sum`=0x0001_0001, `cout`=0.
- ADD 0x7FFF_FFFF + 1 -> `sum`=0x8000_0000, `overflow`=1, `negative`=1, `cout`=0. SUB 0x8000_0000 − 1 -> `sum`=0x7FFF_FFFF, `overflow`=1, `cout`=1.
- Issue 4 back-to-back ops while `out_ready`=0 for 3 cycles after the first result:
  - `in_ready` goes low while stalled.
  - All 4 results appear in order and outputs are held stable during the stall.
- `flush` asserted with 2 ops in flight and `in_valid`=1 -> the op is not accepted, `out_valid`=0 for the next `STAGES` cycles, and the next accepted op produces the correct result.
- `rst` asserted mid-stream for one cycle -> all outputs 0 next cycle, `in_ready`=1 after release, and no stale result emitted.
